// File: rtl/traffic_pkg.sv
// Shared state codes and {R,Y,G} lamp constants for the traffic controller and pattern selector.
// No logic; types and a combinational next-phase helper.
// No flow control.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        AR1   = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        AR2   = 3'd5,
        NIGHT = 3'd6
    } state_t;

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // Normal day cycle order; NIGHT is left via its own exit path.
    function automatic state_t next_state(input state_t s);
        case (s)
            NS_G:    next_state = NS_Y;
            NS_Y:    next_state = AR1;
            AR1:     next_state = EW_G;
            EW_G:    next_state = EW_Y;
            EW_Y:    next_state = AR2;
            default: next_state = NS_G;
        endcase
    endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: pulses tick for one clk when the count reaches CLK_DIV-1.
// Latency: first tick CLK_DIV cycles after reset release.
// No backpressure; free running.
module tick_gen #(
    parameter int CLK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_ctrl_param.sv
// Four-way traffic light controller with pedestrian shortening/walk and night flashing mode.
// Latency: lamps follow the state register directly; BCD digits lag the count register by one clk.
// No backpressure; ped_req is latched and serviced at the next all-red phase.
module traffic_ctrl_param
    import traffic_pkg::*;
#(
    parameter int CLK_DIV   = 50000000,
    parameter int GREEN_S   = 20,
    parameter int YELLOW_S  = 3,
    parameter int ALLRED_S  = 2,
    parameter int PED_SHORT = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       night,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [3:0] cnt_tens,
    output logic [3:0] cnt_ones,
    output logic [2:0] phase,
    output logic       ped_walk,
    output logic       ped_pend
);

    localparam int WALK_S = (ALLRED_S > PED_SHORT) ? ALLRED_S : PED_SHORT;

    localparam logic [6:0] GREEN_D  = 7'(GREEN_S);
    localparam logic [6:0] YELLOW_D = 7'(YELLOW_S);
    localparam logic [6:0] ALLRED_D = 7'(ALLRED_S);
    localparam logic [6:0] WALK_D   = 7'(WALK_S);
    localparam logic [6:0] SHORT_D  = 7'(PED_SHORT);

    logic       tick;
    state_t     state, state_nxt;
    logic [6:0] count, count_nxt;
    logic       flash, flash_nxt;
    logic       pend_nxt, walk_nxt;
    logic       is_green;

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign is_green = (state == NS_G) || (state == EW_G);

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        flash_nxt = flash;
        pend_nxt  = ped_pend;
        walk_nxt  = ped_walk;

        if (state != NIGHT && ped_req) begin
            pend_nxt = 1'b1;
        end

        // Priority: night entry, then expiry, then pedestrian clamp.
        if (tick && night && state != NIGHT) begin
            state_nxt = NIGHT;
            count_nxt = '0;
            flash_nxt = 1'b1;
            pend_nxt  = 1'b0;
            walk_nxt  = 1'b0;
        end else if (state == NIGHT) begin
            if (tick) begin
                if (night) begin
                    flash_nxt = ~flash;
                end else begin
                    state_nxt = AR2;
                    count_nxt = ALLRED_D;
                    flash_nxt = 1'b0;
                end
            end
        end else if (tick && count == 7'd1) begin
            state_nxt = next_state(state);
            walk_nxt  = 1'b0;
            case (state_nxt)
                NS_G, EW_G: count_nxt = GREEN_D;
                NS_Y, EW_Y: count_nxt = YELLOW_D;
                default: begin
                    if (ped_pend || ped_req) begin
                        walk_nxt  = 1'b1;
                        pend_nxt  = 1'b0;
                        count_nxt = WALK_D;
                    end else begin
                        count_nxt = ALLRED_D;
                    end
                end
            endcase
        end else begin
            if (tick) begin
                count_nxt = count - 7'd1;
            end
            if (is_green && (ped_pend || ped_req) && count > SHORT_D) begin
                count_nxt = SHORT_D;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= NS_G;
            count    <= GREEN_D;
            flash    <= 1'b0;
            ped_pend <= 1'b0;
            ped_walk <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            flash    <= flash_nxt;
            ped_pend <= pend_nxt;
            ped_walk <= walk_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_tens <= 4'(GREEN_S / 10);
            cnt_ones <= 4'(GREEN_S % 10);
        end else begin
            cnt_tens <= 4'(count / 7'd10);
            cnt_ones <= 4'(count % 7'd10);
        end
    end

    always_comb begin
        ns_light = LAMP_R;
        ew_light = LAMP_R;
        case (state)
            NS_G:  ns_light = LAMP_G;
            NS_Y:  ns_light = LAMP_Y;
            EW_G:  ew_light = LAMP_G;
            EW_Y:  ew_light = LAMP_Y;
            NIGHT: begin
                ns_light = flash ? LAMP_Y : LAMP_OFF;
                ew_light = flash ? LAMP_Y : LAMP_OFF;
            end
            default: ;
        endcase
    end

    assign phase = state;

endmodule
